// File: rtl/multiport_register_file.sv
// Multi-port register file: NUM_READ registered read ports, one write port with
// optional same-edge bypass, optional hardwired-zero register and a pending-write scoreboard.
module multiport_register_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_READ       = 2,
    parameter bit ZERO_REG       = 1'b1,
    parameter bit BYPASS         = 1'b1,
    parameter bit RESET_TO_INDEX = 1'b1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_READ-1:0]            rd_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           resv_en,
    input  logic [ADDR_WIDTH-1:0]          resv_addr,
    output logic [(2**ADDR_WIDTH)-1:0]     busy_vec
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic                  wr_ok;
    logic                  resv_ok;

    function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
        if (ZERO_REG && idx == 0) begin
            return '0;
        end
        return RESET_TO_INDEX ? DATA_WIDTH'(idx) : '0;
    endfunction

    // Accesses to a hardwired-zero register are dropped before they touch state.
    assign wr_ok   = wr_en   && !(ZERO_REG && wr_addr == '0);
    assign resv_ok = resv_en && !(ZERO_REG && resv_addr == '0);

    // A reservation is applied after the write so the new producer stays outstanding.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (resv_ok) begin
            busy_d[resv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= reset_value(i);
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data_d;
        logic [DATA_WIDTH-1:0] data_q;
        logic                  busy_rd_d;
        logic                  busy_rd_q;

        assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // With bypass the port sees the post-edge register and scoreboard state.
        always_comb begin
            data_d    = data_q;
            busy_rd_d = busy_rd_q;
            if (rd_en[p]) begin
                if (BYPASS && wr_ok && wr_addr == addr) begin
                    data_d = wr_data;
                end else begin
                    data_d = regs_q[addr];
                end
                busy_rd_d = BYPASS ? busy_d[addr] : busy_q[addr];
                if (ZERO_REG && addr == '0) begin
                    data_d    = '0;
                    busy_rd_d = 1'b0;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                data_q    <= '0;
                busy_rd_q <= 1'b0;
            end else begin
                data_q    <= data_d;
                busy_rd_q <= busy_rd_d;
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data_q;
        assign rd_busy[p]                          = busy_rd_q;
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: a default instance (bypass, zero reg) and a
// 4-port 64-bit instance without bypass or zero reg, driven from shared stimulus.
module tb_multiport_register_file;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rd_en_w;
    logic [19:0]  rd_addr_w;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data_w;
    logic         resv_en;
    logic [4:0]   resv_addr;

    logic [63:0]  rd_data_a;
    logic [1:0]   rd_busy_a;
    logic [31:0]  busy_vec_a;
    logic [255:0] rd_data_b;
    logic [3:0]   rd_busy_b;
    logic [31:0]  busy_vec_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    multiport_register_file #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2),
        .ZERO_REG(1'b1), .BYPASS(1'b1), .RESET_TO_INDEX(1'b1)
    ) dut_a (
        .clock(clk), .reset(rst),
        .rd_en(rd_en_w[1:0]), .rd_addr(rd_addr_w[9:0]),
        .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data_w[31:0]),
        .resv_en(resv_en), .resv_addr(resv_addr),
        .busy_vec(busy_vec_a)
    );

    multiport_register_file #(
        .DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(4),
        .ZERO_REG(1'b0), .BYPASS(1'b0), .RESET_TO_INDEX(1'b1)
    ) dut_b (
        .clock(clk), .reset(rst),
        .rd_en(rd_en_w), .rd_addr(rd_addr_w),
        .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data_w),
        .resv_en(resv_en), .resv_addr(resv_addr),
        .busy_vec(busy_vec_b)
    );

    // Reference model: index 0 mirrors dut_a's configuration, index 1 mirrors dut_b's.
    localparam int P_NR   [2] = '{2, 4};
    localparam int P_BYP  [2] = '{1, 0};
    localparam int P_ZERO [2] = '{1, 0};

    logic [63:0] m_reg  [2][32];
    bit          m_busy [2][32];
    logic [63:0] m_rd   [2][4];
    bit          m_rdb  [2][4];

    task automatic model_step(input int k);
        logic [63:0] mask;
        logic [63:0] wd;
        bit          w_ok;
        bit          r_ok;
        bit          post_busy;
        logic [4:0]  a;
        mask = (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        wd   = wr_data_w & mask;
        w_ok = wr_en   && !(P_ZERO[k] != 0 && wr_addr == 5'd0);
        r_ok = resv_en && !(P_ZERO[k] != 0 && resv_addr == 5'd0);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[k][i]  = (P_ZERO[k] != 0 && i == 0) ? 64'd0 : 64'(i);
                m_busy[k][i] = 1'b0;
            end
            for (int p = 0; p < 4; p++) begin
                m_rd[k][p]  = 64'd0;
                m_rdb[k][p] = 1'b0;
            end
            return;
        end
        for (int p = 0; p < P_NR[k]; p++) begin
            if (rd_en_w[p]) begin
                a = rd_addr_w[p*5 +: 5];
                if (r_ok && resv_addr == a)      post_busy = 1'b1;
                else if (w_ok && wr_addr == a)   post_busy = 1'b0;
                else                             post_busy = m_busy[k][a];
                if (P_ZERO[k] != 0 && a == 5'd0) begin
                    m_rd[k][p]  = 64'd0;
                    m_rdb[k][p] = 1'b0;
                end else if (P_BYP[k] != 0) begin
                    m_rd[k][p]  = (w_ok && wr_addr == a) ? wd : m_reg[k][a];
                    m_rdb[k][p] = post_busy;
                end else begin
                    m_rd[k][p]  = m_reg[k][a];
                    m_rdb[k][p] = m_busy[k][a];
                end
            end
        end
        if (w_ok) begin
            m_reg[k][wr_addr]  = wd;
            m_busy[k][wr_addr] = 1'b0;
        end
        if (r_ok) m_busy[k][resv_addr] = 1'b1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else n_pass++;
    endtask

    task automatic model_check();
        logic [63:0] act;
        logic [31:0] bv;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < P_NR[k]; p++) begin
                act = (k == 0) ? {32'd0, rd_data_a[p*32 +: 32]} : rd_data_b[p*64 +: 64];
                chk($sformatf("model_rd_data[%0d][%0d]", k, p), act, m_rd[k][p]);
                act = (k == 0) ? 64'(rd_busy_a[p]) : 64'(rd_busy_b[p]);
                chk($sformatf("model_rd_busy[%0d][%0d]", k, p), act, 64'(m_rdb[k][p]));
            end
            for (int i = 0; i < 32; i++) bv[i] = m_busy[k][i];
            act = (k == 0) ? 64'(busy_vec_a) : 64'(busy_vec_b);
            chk($sformatf("model_busy_vec[%0d]", k), act, 64'(bv));
        end
    endtask

    // Inputs are already set at a negedge; step the models, cross the edge, settle.
    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rd_en_w = '0; rd_addr_w = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data_w = '0;
        resv_en = 1'b0; resv_addr = '0;
    endtask

    typedef struct {
        bit        rst;
        bit [1:0]  ren;
        bit [4:0]  ra0;
        bit [4:0]  ra1;
        bit        we;
        bit [4:0]  wa;
        bit [31:0] wd;
        bit        re;
        bit [4:0]  rsa;
        bit [31:0] e_rd0;
        bit [31:0] e_rd1;
        bit [1:0]  e_rdb;
        bit [31:0] e_bv;
    } vec_t;

    vec_t vt [16];

    initial begin
        idle();
        rst = 1'b1;

        //            rst ren  ra0 ra1 we wa  wd            re rsa  rd0           rd1       rdb    bv
        vt[0]  = '{1, 2'b00, 0,  0,  0, 0,  32'h0,        0, 0,  32'h0,        32'h0,    2'b00, 32'h0};
        vt[1]  = '{0, 2'b11, 0,  7,  0, 0,  32'h0,        0, 0,  32'h0,        32'd7,    2'b00, 32'h0};
        vt[2]  = '{0, 2'b01, 31, 0,  0, 0,  32'h0,        0, 0,  32'd31,       32'd7,    2'b00, 32'h0};
        vt[3]  = '{0, 2'b01, 5,  0,  1, 5,  32'hDEADBEEF, 0, 0,  32'hDEADBEEF, 32'd7,    2'b00, 32'h0};
        vt[4]  = '{0, 2'b00, 0,  0,  0, 0,  32'h0,        1, 9,  32'hDEADBEEF, 32'd7,    2'b00, 32'h200};
        vt[5]  = '{0, 2'b10, 0,  9,  0, 0,  32'h0,        0, 0,  32'hDEADBEEF, 32'd9,    2'b10, 32'h200};
        vt[6]  = '{0, 2'b00, 0,  0,  1, 9,  32'h1234,     0, 0,  32'hDEADBEEF, 32'd9,    2'b10, 32'h0};
        vt[7]  = '{0, 2'b10, 0,  9,  0, 0,  32'h0,        0, 0,  32'hDEADBEEF, 32'h1234, 2'b00, 32'h0};
        vt[8]  = '{0, 2'b01, 12, 0,  1, 12, 32'hA5,       1, 12, 32'hA5,       32'h1234, 2'b01, 32'h1000};
        vt[9]  = '{0, 2'b01, 12, 0,  0, 0,  32'h0,        0, 0,  32'hA5,       32'h1234, 2'b01, 32'h1000};
        vt[10] = '{0, 2'b11, 0,  0,  1, 0,  32'hFFFFFFFF, 1, 0,  32'h0,        32'h0,    2'b00, 32'h1000};
        vt[11] = '{0, 2'b00, 0,  0,  0, 0,  32'h0,        1, 8,  32'h0,        32'h0,    2'b00, 32'h1100};
        vt[12] = '{0, 2'b00, 0,  0,  1, 12, 32'h77,       1, 9,  32'h0,        32'h0,    2'b00, 32'h300};
        vt[13] = '{1, 2'b11, 3,  4,  1, 3,  32'hFFFF,     1, 4,  32'h0,        32'h0,    2'b00, 32'h0};
        vt[14] = '{0, 2'b11, 3,  12, 0, 0,  32'h0,        0, 0,  32'd3,        32'd12,   2'b00, 32'h0};
        vt[15] = '{0, 2'b11, 5,  9,  0, 0,  32'h0,        0, 0,  32'd5,        32'd9,    2'b00, 32'h0};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rst       = vt[i].rst;
            rd_en_w   = {2'b00, vt[i].ren};
            rd_addr_w = {10'd0, vt[i].ra1, vt[i].ra0};
            wr_en     = vt[i].we;
            wr_addr   = vt[i].wa;
            wr_data_w = {32'd0, vt[i].wd};
            resv_en   = vt[i].re;
            resv_addr = vt[i].rsa;
            cycle();
            chk($sformatf("vec%0d_rd0", i), 64'(rd_data_a[31:0]), 64'(vt[i].e_rd0));
            chk($sformatf("vec%0d_rd1", i), 64'(rd_data_a[63:32]), 64'(vt[i].e_rd1));
            chk($sformatf("vec%0d_rdb", i), 64'(rd_busy_a), 64'(vt[i].e_rdb));
            chk($sformatf("vec%0d_bv", i), 64'(busy_vec_a), 64'(vt[i].e_bv));
            model_check();
            @(negedge clk);
        end

        // No-bypass instance: same-edge read returns the old value, next read the new one.
        idle(); rst = 1'b1;
        cycle(); @(negedge clk);
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data_w = 64'hDEADBEEF_CAFE0001;
        rd_en_w = 4'b0001; rd_addr_w = {15'd0, 5'd5};
        cycle();
        chk("nobyp_old", rd_data_b[63:0], 64'd5);
        chk("byp_new", 64'(rd_data_a[31:0]), 64'hCAFE0001);
        @(negedge clk);
        idle();
        rd_en_w = 4'b0001; rd_addr_w = {15'd0, 5'd5};
        cycle();
        chk("nobyp_new", rd_data_b[63:0], 64'hDEADBEEF_CAFE0001);
        @(negedge clk);

        // Four ports, four addresses, then one port alone: the others must hold.
        idle();
        rd_en_w = 4'b1111; rd_addr_w = {5'd5, 5'd3, 5'd2, 5'd1};
        cycle();
        chk("x4_p0", rd_data_b[63:0], 64'd1);
        chk("x4_p1", rd_data_b[127:64], 64'd2);
        chk("x4_p2", rd_data_b[191:128], 64'd3);
        chk("x4_p3", rd_data_b[255:192], 64'hDEADBEEF_CAFE0001);
        @(negedge clk);
        idle();
        rd_en_w = 4'b0100; rd_addr_w = {5'd0, 5'd7, 5'd0, 5'd0};
        cycle();
        chk("x1_p0_hold", rd_data_b[63:0], 64'd1);
        chk("x1_p1_hold", rd_data_b[127:64], 64'd2);
        chk("x1_p2_new", rd_data_b[191:128], 64'd7);
        chk("x1_p3_hold", rd_data_b[255:192], 64'hDEADBEEF_CAFE0001);
        model_check();
        @(negedge clk);

        // Randomized traffic against the model, with narrow addresses to force collisions.
        for (int n = 0; n < 800; n++) begin
            rst     = ($urandom_range(0, 59) == 0);
            rd_en_w = 4'($urandom);
            for (int p = 0; p < 4; p++) begin
                rd_addr_w[p*5 +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            end
            wr_en     = ($urandom_range(0, 1) != 0);
            wr_addr   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wr_data_w = {$urandom, $urandom};
            resv_en   = ($urandom_range(0, 2) == 0);
            resv_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            cycle();
            model_check();
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
- Parametrised successor to the single-issue 32x32 register file.
- Provides NUM_READ registered read ports, one posedge write port with same-cycle write-to-read bypass, an optional hardwired-zero register, and a per-register scoreboard of pending writes.
- Sits between decode (read addresses, reservations) and writeback (write port); the hazard unit consumes the busy flags.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and reservations
BYPASS, 1, 1 = read of a register being written in the same cycle returns the new data
RESET_TO_INDEX, 1, 1 = reset loads register i with value i; 0 = reset loads 0

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
rd_en  in  NUM_READ  per-port read enable
rd_addr  in  NUM_READ*ADDR_WIDTH  read addresses; port p uses slice p
rd_data  out  NUM_READ*DATA_WIDTH  registered read data; port p uses slice p
rd_busy  out  NUM_READ  registered scoreboard bit of the addressed register
wr_en  in  1  write enable
wr_addr  in  ADDR_WIDTH  write address (rd/rt selection is made upstream)
wr_data  in  DATA_WIDTH  write-back data
resv_en  in  1  mark a register as pending write (instruction issued)
resv_addr  in  ADDR_WIDTH  register to reserve
busy_vec  out  2**ADDR_WIDTH  live (unregistered) scoreboard bits, bit i = register i

Behaviour:
- Reset (sampled at the rising edge while reset=1):
  - register i <= (RESET_TO_INDEX ? i : 0), truncated to DATA_WIDTH; register 0 <= 0 when ZERO_REG=1.
  - All busy bits <= 0; rd_data <= 0; rd_busy <= 0.
  - Reset overrides wr_en and resv_en in the same cycle.
  - A reset asserted mid-stream discards any in-flight reservation; there is no partial state.
- Read, latency 1:
  - On a rising edge with rd_en[p]=1, rd_data[p] <= register[rd_addr[p]] and rd_busy[p] <= busy[rd_addr[p]].
  - With rd_en[p]=0, rd_data[p] and rd_busy[p] hold their previous values.
  - Ports are fully independent; the same address on several ports is legal.
- Write:
  - On a rising edge with wr_en=1, register[wr_addr] <= wr_data. There is a single write per cycle; no negedge logic.
- Bypass, same edge, wr_en=1, rd_en[p]=1, rd_addr[p]==wr_addr:
  - BYPASS=1: rd_data[p] <= wr_data and rd_busy[p] <= 0, unless the same-cycle reservation rule below applies.
  - BYPASS=0: rd_data[p] <= the old register value and rd_busy[p] <= the old busy bit.
- Scoreboard, per register i, evaluated on the rising edge:
  - resv_en=1 and resv_addr==i: busy[i] <= 1. Reservation wins over a simultaneous write to i, because the new producer is still outstanding.
  - Otherwise, wr_en=1 and wr_addr==i: busy[i] <= 0.
  - Otherwise busy[i] holds.
  - With BYPASS=1, rd_busy[p] for a same-edge read of i reflects the post-edge busy value.
  - Reserving an already-busy register is legal; the bit stays 1 (no counting).
- ZERO_REG=1:
  - Writes and reservations to address 0 are dropped.
  - Reads of address 0 return 0 and busy 0, including under bypass.
  - busy_vec[0] = 0.
- X handling: rd_addr, wr_addr and resv_addr are don't-care while their enable is low; no state may change from them.
- Implementation: a flop array, no RAM macro inference required. Read mux and scoreboard are generated per port from NUM_READ.

Test Plan:
- Reset with defaults, then read addresses 0, 7 and 31 on ports 0/1 over consecutive cycles -> rd_data = 0, 7, 31 one cycle after each rd_en; rd_busy = 0.
- Write 0xDEADBEEF to register 5 while port 0 reads 5 in the same cycle:
  - BYPASS=1 -> rd_data[0] = 0xDEADBEEF next cycle.
  - BYPASS=0 -> rd_data[0] = 5, then 0xDEADBEEF on the following read.
- resv_en to register 9; read 9 next cycle -> rd_busy = 1 and busy_vec[9] = 1. Then write 9 with 0x1234 -> busy_vec[9] = 0, and a read returns 0x1234 with busy 0.
- Same cycle: resv_en to 12 and wr_en to 12 (data 0xA5) -> register 12 = 0xA5 and busy_vec[12] remains 1.
- ZERO_REG=1: write 0xFFFF_FFFF to 0 plus resv_en to 0 -> read of 0 gives 0, busy 0, busy_vec[0] = 0.
- Reset asserted while busy_vec = 0x0000_0300 and wr_en=1 to register 3 -> next cycle busy_vec = 0, register 3 = 3, rd_data = 0. Rerun with NUM_READ=4, DATA_WIDTH=64 to confirm port slicing and no cross-port interference.
